dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_sram.sv | 41 ++++
 rtl/dmem_ctrl.sv | 144 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared constants and the controller state encoding for the data-memory
// controller slice (dmem_ctrl and its storage sub-module dmem_sram).
//   DATA_WIDTH  : data word width in bits
//   DEPTH_WORDS : number of memory words (power of two)
//   ADDR_WIDTH  : word-index width, log2(DEPTH_WORDS)
//   state_t     : IDLE services CPU accesses, CLEAR zeroes the array
package dmem_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int DEPTH_WORDS = 1024;
    localparam int ADDR_WIDTH  = $clog2(DEPTH_WORDS);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_sram.sv
// dmem_sram
// Single-port synchronous word memory with per-byte write enables.
// Reads are read-first: a read and a write to the same word in one cycle
// return the old contents. The read register holds its value when rd_en is
// low. There is no reset; contents survive controller resets.
// Ports:
//   clk   : clock
//   we    : byte-lane write enables, bit i covers wdata[8i+7:8i]
//   addr  : word index shared by read and write
//   wdata : write data
//   rd_en : load rdata from mem[addr] on this edge
//   rdata : registered read data
module dmem_sram #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                      clk,
    input  logic [DATA_WIDTH/8-1:0]   we,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic                      rd_en,
    output logic [DATA_WIDTH-1:0]     rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Non-blocking read and write in the same block gives read-first
    // behaviour for a same-word collision.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata <= mem[addr];
        end
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl
// Data-memory controller for the CPU MEM stage. Decodes byte addresses into
// word indices, rejects out-of-range accesses with a one-cycle err pulse,
// muxes the storage port between CPU writes and a whole-memory clear, and
// registers read data.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst_n     : synchronous active-low reset (does not touch memory contents)
//   RD / WR   : read / write requests
//   A_DMEM    : byte address; bits [1:0] ignored
//   D_out     : write data from the CPU
//   byte_mark : byte-lane write enables
//   DMEM_rst  : start (or restart) clearing the whole memory
//   D_in      : read data, valid one cycle after RD, held between reads
//   busy      : high while a clear is running
//   err       : one-cycle pulse the cycle after an out-of-range access
module dmem_ctrl #(
    parameter int DATA_WIDTH  = dmem_pkg::DATA_WIDTH,
    parameter int DEPTH_WORDS = dmem_pkg::DEPTH_WORDS,
    parameter int ADDR_WIDTH  = $clog2(DEPTH_WORDS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      RD,
    input  logic                      WR,
    input  logic [31:0]               A_DMEM,
    input  logic [DATA_WIDTH-1:0]     D_out,
    input  logic [DATA_WIDTH/8-1:0]   byte_mark,
    input  logic                      DMEM_rst,
    output logic [DATA_WIDTH-1:0]     D_in,
    output logic                      busy,
    output logic                      err
);

    import dmem_pkg::*;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [ADDR_WIDTH-1:0]   clr_cnt_nxt;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    out_of_range;
    logic [DATA_WIDTH/8-1:0] sram_we;
    logic [ADDR_WIDTH-1:0]   sram_addr;
    logic [DATA_WIDTH-1:0]   sram_wdata;
    logic                    sram_rd;
    logic [DATA_WIDTH-1:0]   sram_rdata;
    logic                    err_nxt;
    logic                    zero_rd;

    assign word_idx     = A_DMEM[ADDR_WIDTH+1:2];
    assign out_of_range = |A_DMEM[31:ADDR_WIDTH+2];

    // Next-state logic. A DMEM_rst seen during CLEAR restarts the sweep from
    // word 0; the sweep ends on the edge that writes the last word, so a
    // clear spends exactly DEPTH_WORDS cycles in CLEAR.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                if (DMEM_rst) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (DMEM_rst) begin
                    clr_cnt_nxt = '0;
                end else if (clr_cnt == ADDR_WIDTH'(DEPTH_WORDS - 1)) begin
                    state_nxt   = IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_nxt   = IDLE;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // Storage port mux. Every write is gated by rst_n so a reset cycle can
    // neither complete a CPU write nor zero the word under the clear counter.
    // CPU accesses are ignored entirely while clearing, including err.
    always_comb begin
        sram_we    = '0;
        sram_addr  = word_idx;
        sram_wdata = D_out;
        sram_rd    = 1'b0;
        err_nxt    = 1'b0;
        if (rst_n) begin
            if (state == CLEAR) begin
                sram_we    = '1;
                sram_addr  = clr_cnt;
                sram_wdata = '0;
            end else begin
                if (WR && !out_of_range) begin
                    sram_we = byte_mark;
                end
                sram_rd = RD && !out_of_range;
                err_nxt = out_of_range && (RD || (WR && (|byte_mark)));
            end
        end
    end

    // Control registers. zero_rd remembers whether the most recent RD was
    // refused (out of range, during CLEAR, or never happened since reset);
    // it masks the SRAM read register, which only loads on accepted reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
            err     <= 1'b0;
            zero_rd <= 1'b1;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            err     <= err_nxt;
            if (RD) begin
                zero_rd <= !sram_rd;
            end
        end
    end

    assign D_in = zero_rd ? '0 : sram_rdata;

    dmem_sram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (sram_wdata),
        .rd_en (sram_rd),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl
// Self-checking bench for dmem_ctrl. Keeps a word-level image of the memory
// and predicts read data, err and busy from the behavioural rules.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        RD;
    logic        WR;
    logic [31:0] A_DMEM;
    logic [31:0] D_out;
    logic [3:0]  byte_mark;
    logic        DMEM_rst;
    logic [31:0] D_in;
    logic        busy;
    logic        err;

    int          total;
    int          bad;
    logic [31:0] ref_mem [1024];

    dmem_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RD        (RD),
        .WR        (WR),
        .A_DMEM    (A_DMEM),
        .D_out     (D_out),
        .byte_mark (byte_mark),
        .DMEM_rst  (DMEM_rst),
        .D_in      (D_in),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RD        = 1'b0;
        WR        = 1'b0;
        DMEM_rst  = 1'b0;
        A_DMEM    = 32'h0;
        D_out     = 32'h0;
        byte_mark = 4'h0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  mark);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mark[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mark);
        WR = 1'b1; A_DMEM = addr; D_out = data; byte_mark = mark;
        tick();
        idle_inputs();
        ref_mem[addr[11:2]] = merge(ref_mem[addr[11:2]], data, mark);
    endtask

    task automatic cpu_read(input logic [31:0] addr);
        RD = 1'b1; A_DMEM = addr;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        RD = 1'b1; DMEM_rst = 1'b1; A_DMEM = 32'h0000_2000;
        tick();
        tick();
        total++;
        if (D_in !== 32'h0) begin bad++; $display("[TB] FAIL reset_d_in: got %h want 0", D_in); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", err); end
        idle_inputs();
        rst_n = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_write();
        cpu_write(32'h40, 32'hDEADBEEF, 4'hF);
        cpu_read(32'h40);
        total++;
        if (D_in !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL full_write: got %h want deadbeef", D_in); end
        tick();
        tick();
        total++;
        if (D_in !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL d_in_hold: got %h want deadbeef", D_in); end
    endtask

    task automatic test_partial_write();
        cpu_write(32'h40, 32'h00001122, 4'b0011);
        cpu_write(32'h40, 32'h77777777, 4'b0000);
        total++;
        if (err !== 1'b0) begin bad++; $display("[TB] FAIL mark0_err: got %b want 0", err); end
        cpu_read(32'h40);
        total++;
        if (D_in !== 32'hDEAD1122) begin bad++; $display("[TB] FAIL partial_write: got %h want dead1122", D_in); end
    endtask

    task automatic test_rd_wr_same();
        cpu_write(32'h80, 32'h12345678, 4'hF);
        RD = 1'b1; WR = 1'b1; A_DMEM = 32'h80; D_out = 32'hCAFEF00D; byte_mark = 4'hF;
        tick();
        idle_inputs();
        ref_mem[32] = 32'hCAFEF00D;
        total++;
        if (D_in !== 32'h12345678) begin bad++; $display("[TB] FAIL rdwr_old: got %h want 12345678", D_in); end
        cpu_read(32'h80);
        total++;
        if (D_in !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL rdwr_new: got %h want cafef00d", D_in); end
    endtask

    task automatic test_out_of_range();
        cpu_read(32'h0000_1000);
        total++;
        if (D_in !== 32'h0) begin bad++; $display("[TB] FAIL oor_rd_data: got %h want 0", D_in); end
        total++;
        if (err !== 1'b1) begin bad++; $display("[TB] FAIL oor_rd_err: got %b want 1", err); end
        tick();
        total++;
        if (err !== 1'b0) begin bad++; $display("[TB] FAIL oor_err_width: got %b want 0", err); end
        WR = 1'b1; A_DMEM = 32'h0000_1040; D_out = 32'h55555555; byte_mark = 4'hF;
        tick();
        idle_inputs();
        total++;
        if (err !== 1'b1) begin bad++; $display("[TB] FAIL oor_wr_err: got %b want 1", err); end
        cpu_read(32'h43);
        total++;
        if (D_in !== 32'hDEAD1122) begin bad++; $display("[TB] FAIL oor_mem_kept: got %h want dead1122", D_in); end
    endtask

    task automatic test_clear();
        int n;
        cpu_write(32'h0, 32'hFFFFFFFF, 4'hF);
        cpu_write(32'hFFC, 32'hFFFFFFFF, 4'hF);
        DMEM_rst = 1'b1;
        tick();
        DMEM_rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            RD = (n == 5); WR = (n == 700);
            A_DMEM = (n == 5) ? 32'hFFC : 32'h0;
            D_out = 32'hA5A5A5A5; byte_mark = 4'hF;
            tick();
            if (n == 5) begin
                total++;
                if (D_in !== 32'h0) begin bad++; $display("[TB] FAIL clear_rd_busy: got %h want 0", D_in); end
                total++;
                if (err !== 1'b0) begin bad++; $display("[TB] FAIL clear_rd_err: got %b want 0", err); end
            end
            n++;
        end
        idle_inputs();
        total++;
        if (n != 1024) begin bad++; $display("[TB] FAIL clear_len: got %0d want 1024", n); end
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        cpu_write(32'h40, 32'h0BADF00D, 4'hF);
        cpu_read(32'h0);
        total++;
        if (D_in !== 32'h0) begin bad++; $display("[TB] FAIL clear_word0: got %h want 0", D_in); end
        cpu_read(32'h40);
        cpu_read(32'hFFC);
        total++;
        if (D_in !== 32'h0) begin bad++; $display("[TB] FAIL clear_word1023: got %h want 0", D_in); end
    endtask

    task automatic test_random();
        logic [31:0] exp_d;
        logic        exp_e;
        logic        oor;
        int          idx;
        exp_d = D_in === 32'h0 ? 32'h0 : 32'h0;
        for (int k = 0; k < 300; k++) begin
            oor = ($urandom_range(0, 9) == 0);
            idx = $urandom_range(0, 15);
            RD = $urandom_range(0, 1);
            WR = $urandom_range(0, 1);
            D_out = $urandom;
            byte_mark = $urandom;
            if (oor) begin
                A_DMEM = $urandom | 32'h0000_1000;
                if (byte_mark == 4'h0) byte_mark = 4'h1;
            end else begin
                A_DMEM = {20'h0, 10'(idx), 2'($urandom)};
            end
            if (RD) exp_d = oor ? 32'h0 : ref_mem[idx];
            exp_e = oor && (RD || WR);
            if (WR && !oor) ref_mem[idx] = merge(ref_mem[idx], D_out, byte_mark);
            tick();
            total++;
            if (D_in !== exp_d) begin bad++; $display("[TB] FAIL rand_d_in[%0d]: got %h want %h", k, D_in, exp_d); end
            total++;
            if (err !== exp_e) begin bad++; $display("[TB] FAIL rand_err[%0d]: got %b want %b", k, err, exp_e); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < 12; i++) cpu_write(32'(i * 4), 32'h1000 + 32'(i), 4'hF);
        DMEM_rst = 1'b1;
        tick();
        DMEM_rst = 1'b0;
        repeat (10) tick();
        total++;
        if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midclr_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midclr_abort: got %b want 0", busy); end
        for (int i = 0; i < 10; i++) ref_mem[i] = 32'h0;
        for (int i = 0; i < 12; i++) begin
            cpu_read(32'(i * 4));
            total++;
            if (D_in !== ref_mem[i]) begin bad++; $display("[TB] FAIL midclr_word%0d: got %h want %h", i, D_in, ref_mem[i]); end
        end
    endtask

    task automatic test_clear_restart();
        int n;
        DMEM_rst = 1'b1;
        tick();
        DMEM_rst = 1'b0;
        repeat (500) tick();
        total++;
        if (busy !== 1'b1) begin bad++; $display("[TB] FAIL restart_busy500: got %b want 1", busy); end
        DMEM_rst = 1'b1;
        tick();
        DMEM_rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        total++;
        if (n != 1024) begin bad++; $display("[TB] FAIL restart_len: got %0d want 1024", n); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        test_reset();
        test_full_write();
        test_partial_write();
        test_rd_wr_same();
        test_out_of_range();
        test_clear();
        test_random();
        test_reset_mid_clear();
        test_clear_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
